// File: rtl/alu_unit_if.sv
// Execute-stage ALU handshake bundle.
// Request side (operands) and registered response side (result, flags).
interface alu_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_control;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, alu_control,
    input  out_valid, result, zero,
    input  negative, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, alu_control,
    output out_valid, result, zero,
    output negative, carry, overflow
  );
endinterface

// File: rtl/alu_unit.sv
// 32-bit integer ALU for the execute stage.
// One-cycle registered result with zero/negative/carry/overflow flags.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_unit_if.slave   bus
);
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             msb_a;
  logic             msb_b;
  logic             lt_s;
  logic             lt_u;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;

  logic             valid_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             ovf_q;

  assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
  assign msb_a = bus.a[WIDTH-1];
  assign msb_b = bus.b[WIDTH-1];
  assign lt_u  = diff[WIDTH];
  // Signs differ: a is smaller iff negative; avoids the overflowed diff.
  assign lt_s  = (msb_a != msb_b) ? msb_a : diff[WIDTH-1];

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (bus.alu_control)
      OP_AND:  res_d = bus.a & bus.b;
      OP_OR:   res_d = bus.a | bus.b;
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (msb_a == msb_b)
                && (sum[WIDTH-1] != msb_a);
      end
      OP_XOR:  res_d = bus.a ^ bus.b;
      OP_NOR:  res_d = ~(bus.a | bus.b);
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, lt_u};
      OP_SUB: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = ~diff[WIDTH];
        ovf_d   = (msb_a != msb_b)
                && (diff[WIDTH-1] != msb_a);
      end
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, lt_s};
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        res_q   <= res_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.result    = res_q;
  assign bus.zero      = (res_q == '0);
  assign bus.negative  = res_q[WIDTH-1];
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit.
// Each step drives at negedge and checks just after the next posedge.
module tb_alu_unit;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_unit_if #(.WIDTH(32)) bus ();

  alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(
    input logic        rst,
    input logic        vld,
    input logic [31:0] av,
    input logic [31:0] bv,
    input logic [2:0]  ctl
  );
    @(negedge clk);
    rst_n           = rst;
    bus.in_valid    = vld;
    bus.a           = av;
    bus.b           = bv;
    bus.alu_control = ctl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Checks result plus all flags: packed {ov, z, n, c, o}.
  task automatic chk_all(
    input string       tag,
    input logic [31:0] res,
    input logic [4:0]  fl
  );
    chk({tag, ".result"}, bus.result, res);
    chk({tag, ".flags"},
        {27'b0, bus.out_valid, bus.zero, bus.negative,
         bus.carry, bus.overflow},
        {27'b0, fl});
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.alu_control = 3'b000;

    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    chk_all("reset", 32'h0, 5'b01000);

    drive(1'b1, 1'b1, 32'h0000_8000, 32'h0000_8000, 3'b010);
    chk_all("add", 32'h0001_0000, 5'b10000);

    drive(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h1, 3'b010);
    chk_all("add_ovf", 32'h8000_0000, 5'b10101);

    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 3'b010);
    chk_all("add_cry", 32'h0, 5'b11010);

    drive(1'b1, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000);
    chk_all("and", 32'h00F0_00F0, 5'b10000);

    drive(1'b1, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001);
    chk_all("or", 32'hFFF0_FFF0, 5'b10100);

    drive(1'b1, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011);
    chk_all("xor", 32'hFF00_FF00, 5'b10100);

    drive(1'b1, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100);
    chk_all("nor", 32'h000F_000F, 5'b10000);

    drive(1'b1, 1'b1, 32'h5, 32'h5, 3'b110);
    chk_all("sub_eq", 32'h0, 5'b11010);

    drive(1'b1, 1'b1, 32'h1, 32'h2, 3'b110);
    chk_all("sub_brw", 32'hFFFF_FFFF, 5'b10100);

    drive(1'b1, 1'b1, 32'h8000_0000, 32'h1, 3'b110);
    chk_all("sub_ovf", 32'h7FFF_FFFF, 5'b10011);

    drive(1'b1, 1'b1, 32'h8000_0000, 32'h1, 3'b111);
    chk_all("slt", 32'h1, 5'b10000);

    drive(1'b1, 1'b1, 32'h8000_0000, 32'h1, 3'b101);
    chk_all("sltu", 32'h0, 5'b11000);

    drive(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 3'b111);
    chk_all("slt_pos", 32'h0, 5'b11000);

    drive(1'b1, 1'b1, 32'h1, 32'hFFFF_FFFF, 3'b101);
    chk_all("sltu_big", 32'h1, 5'b10000);

    drive(1'b1, 1'b1, 32'h1, 32'h2, 3'b001);
    chk_all("flow_v1", 32'h3, 5'b10000);

    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 3'b010);
    chk_all("flow_gap", 32'h3, 5'b00000);

    drive(1'b1, 1'b1, 32'h3, 32'h3, 3'b011);
    chk_all("flow_v2", 32'h0, 5'b11000);

    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 3'b010);
    chk_all("pre_rst", 32'h0, 5'b11010);

    drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1, 3'b010);
    chk_all("mid_rst", 32'h0, 5'b01000);

    drive(1'b1, 1'b1, 32'h2, 32'h3, 3'b010);
    chk_all("post_rst", 32'h5, 5'b10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
